// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   - ALU control codes understood by the existing 64-bit ALU
//   - sequencer state encoding (2-bit)
package alu_mul_sequencer_pkg;

    localparam logic [3:0] ALU_CTRL_AND   = 4'h0;
    localparam logic [3:0] ALU_CTRL_OR    = 4'h1;
    localparam logic [3:0] ALU_CTRL_ADD   = 4'h2;
    localparam logic [3:0] ALU_CTRL_SUB   = 4'h6;
    localparam logic [3:0] ALU_CTRL_PASSB = 4'h7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bus between the multiplier sequencer and the shared combinational ALU.
//   alu_a/alu_b/alu_ctrl : operands and operation code towards the ALU
//   alu_w/alu_zero       : combinational result and zero flag back
// master = sequencer side, slave = ALU side.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_w;
    logic             alu_zero;

    modport master (
        output alu_a, alu_b, alu_ctrl,
        input  alu_w, alu_zero
    );

    modport slave (
        input  alu_a, alu_b, alu_ctrl,
        output alu_w, alu_zero
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Iterative shift-add multiplier that borrows the datapath ALU.
// One ALU ADD per multiplier bit; stops as soon as the remaining
// multiplier bits are zero. Returns the low WIDTH bits of the unsigned
// product plus the ALU zero flag of the final ADD.
// Ports:
//   CLK, Reset_L          clock, asynchronous active-low reset
//   start, mcand, mplier  request and operands (sampled in IDLE/DONE)
//   busy, done            high in RUN / one-cycle result-valid pulse
//   product, product_zero result, held until the next DONE
//   aluBus                master side of the ALU bus
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter logic [3:0] CTRL_ADD   = ALU_CTRL_ADD,
    parameter logic [3:0] CTRL_PASSB = ALU_CTRL_PASSB
) (
    input  logic                   CLK,
    input  logic                   Reset_L,
    input  logic                   start,
    input  logic [WIDTH-1:0]       mcand,
    input  logic [WIDTH-1:0]       mplier,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       product,
    output logic                   product_zero,
    alu_mul_sequencer_if.master    aluBus
);

    seqState_t        state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mc;
    logic [WIDTH-1:0] mp;
    logic [WIDTH-1:0] mpNext;

    assign mpNext = mp >> 1;

    // ALU is only borrowed in RUN; otherwise it idles on PassB of zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        aluBus.alu_ctrl = CTRL_PASSB;
        aluBus.alu_a    = '0;
        aluBus.alu_b    = '0;
        if (state == RUN) begin
            aluBus.alu_ctrl = CTRL_ADD;
            aluBus.alu_a    = acc;
            aluBus.alu_b    = mp[0] ? mc : '0;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            product      <= '0;
            product_zero <= 1'b0;
            acc          <= '0;
            mc           <= '0;
            mp           <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every read in this block sees pre-edge values.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc   <= '0;
                        mc    <= mcand;
                        mp    <= mplier;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= aluBus.alu_w;
                    mc  <= mc << 1;
                    mp  <= mpNext;
                    // Early exit: no set bits left means no further ADD can change acc.
                    if (mpNext == '0) begin
                        product      <= aluBus.alu_w;
                        product_zero <= aluBus.alu_zero;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int WIDTH = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic             CLK = 1'b0;
    logic             Reset_L = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] mcand = '0;
    logic [WIDTH-1:0] mplier = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             product_zero;

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer_if #(.WIDTH(WIDTH)) aluBus ();

    alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .start        (start),
        .mcand        (mcand),
        .mplier       (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .product_zero (product_zero),
        .aluBus       (aluBus.master)
    );

    // Reference combinational ALU on the slave side of the bus.
    always_comb begin
        case (aluBus.alu_ctrl)
            ALU_CTRL_AND:   aluBus.alu_w = aluBus.alu_a & aluBus.alu_b;
            ALU_CTRL_OR:    aluBus.alu_w = aluBus.alu_a | aluBus.alu_b;
            ALU_CTRL_ADD:   aluBus.alu_w = aluBus.alu_a + aluBus.alu_b;
            ALU_CTRL_SUB:   aluBus.alu_w = aluBus.alu_a - aluBus.alu_b;
            ALU_CTRL_PASSB: aluBus.alu_w = aluBus.alu_b;
            default:        aluBus.alu_w = '0;
        endcase
    end
    assign aluBus.alu_zero = (aluBus.alu_w == '0);

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [63:0] mcand;
        logic [63:0] mplier;
        logic [63:0] expProduct;
        logic        expZero;
        int          expCycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts RUN edges until done is seen (sampled 1 after each edge).
    task automatic waitDone(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            cycles++;
            if (done) return;
        end
        errors++;
        checks++;
        $display("FAIL %s: timeout waiting for done after %0d cycles", name, cycles);
    endtask

    // Issue a one-cycle start pulse (caller is 1 after an edge).
    task automatic pulseStart(input logic [63:0] a, input logic [63:0] b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        tick();
        start  = 1'b0;
    endtask

    initial begin
        int cycles;
        logic [63:0] expB[3];

        vecs[0] = '{"3x5",        64'd3,                   64'd5,                   64'hF,   1'b0, 3};
        vecs[1] = '{"mplier0",    64'h1234,                64'd0,                   64'd0,   1'b1, 1};
        vecs[2] = '{"wrap",       64'h8000_0000_0000_0000, 64'd2,                   64'd0,   1'b1, 2};
        vecs[3] = '{"1xones",     64'd1,                   ONES,                    ONES,    1'b0, 64};
        vecs[4] = '{"16x16",      64'h10,                  64'h10,                  64'h100, 1'b0, 5};
        vecs[5] = '{"onesxones",  ONES,                    ONES,                    64'd1,   1'b0, 64};
        vecs[6] = '{"7x6",        64'd7,                   64'd6,                   64'd42,  1'b0, 3};
        vecs[7] = '{"0xmsb",      64'd0,                   64'h8000_0000_0000_0000, 64'd0,   1'b1, 64};

        // Reset state.
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_pzero", {63'd0, product_zero}, 64'd0);
        check("rst_ctrl", {60'd0, aluBus.alu_ctrl}, {60'd0, ALU_CTRL_PASSB});
        check("rst_alu_a", aluBus.alu_a, 64'd0);
        check("rst_alu_b", aluBus.alu_b, 64'd0);
        Reset_L = 1'b1;
        tick();
        tick();

        // Table-driven operations.
        foreach (vecs[i]) begin
            pulseStart(vecs[i].mcand, vecs[i].mplier);
            check({vecs[i].name, "_busy"}, {63'd0, busy}, 64'd1);
            waitDone(vecs[i].name, cycles);
            check({vecs[i].name, "_cycles"}, 64'(cycles), 64'(vecs[i].expCycles));
            check({vecs[i].name, "_product"}, product, vecs[i].expProduct);
            check({vecs[i].name, "_pzero"}, {63'd0, product_zero}, {63'd0, vecs[i].expZero});
            check({vecs[i].name, "_busy_done"}, {63'd0, busy}, 64'd0);
            tick();
            check({vecs[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
            check({vecs[i].name, "_idle_ctrl"}, {60'd0, aluBus.alu_ctrl}, {60'd0, ALU_CTRL_PASSB});
        end

        // ALU operand sequence for 3x5: b = 3, 0, 12; a = 0, 3, 3.
        expB[0] = 64'd3; expB[1] = 64'd0; expB[2] = 64'd12;
        pulseStart(64'd3, 64'd5);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seq_alu_b%0d", i), aluBus.alu_b, expB[i]);
            check($sformatf("seq_ctrl%0d", i), {60'd0, aluBus.alu_ctrl}, {60'd0, ALU_CTRL_ADD});
            check($sformatf("seq_alu_a%0d", i), aluBus.alu_a, (i == 0) ? 64'd0 : 64'd3);
            tick();
        end
        check("seq_done", {63'd0, done}, 64'd1);
        check("seq_product", product, 64'hF);
        tick();

        // start during RUN is ignored.
        pulseStart(64'd7, 64'd6);
        start = 1'b1; mcand = 64'd100; mplier = 64'd100;
        tick();
        start = 1'b0;
        waitDone("ignore", cycles);
        check("ignore_cycles", 64'(cycles + 1), 64'd3);
        check("ignore_product", product, 64'd42);
        tick();
        check("ignore_no_restart", {63'd0, busy}, 64'd0);

        // Back-to-back: start held through DONE launches the next op at once.
        start = 1'b1; mcand = 64'd3; mplier = 64'd5;
        tick();
        mcand = 64'd2; mplier = 64'd3;
        waitDone("b2b_first", cycles);
        check("b2b_first_cycles", 64'(cycles), 64'd3);
        check("b2b_first_product", product, 64'hF);
        tick();
        start = 1'b0;
        check("b2b_no_gap_busy", {63'd0, busy}, 64'd1);
        check("b2b_no_gap_done", {63'd0, done}, 64'd0);
        waitDone("b2b_second", cycles);
        check("b2b_second_cycles", 64'(cycles), 64'd2);
        check("b2b_second_product", product, 64'd6);
        tick();

        // Asynchronous reset in the middle of a long operation.
        pulseStart(64'd1, ONES);
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", {63'd0, busy}, 64'd1);
        #2;
        Reset_L = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_product", product, 64'd0);
        check("arst_ctrl", {60'd0, aluBus.alu_ctrl}, {60'd0, ALU_CTRL_PASSB});
        check("arst_alu_a", aluBus.alu_a, 64'd0);
        tick();
        Reset_L = 1'b1;
        begin
            int doneSeen = 0;
            for (int i = 0; i < 70; i++) begin
                tick();
                if (done) doneSeen++;
            end
            check("arst_no_done", 64'(doneSeen), 64'd0);
        end
        check("arst_ctrl_after", {60'd0, aluBus.alu_ctrl}, {60'd0, ALU_CTRL_PASSB});
        check("arst_busy_after", {63'd0, busy}, 64'd0);

        // Block recovers fully after reset.
        pulseStart(64'd9, 64'd9);
        waitDone("recover", cycles);
        check("recover_cycles", 64'(cycles), 64'd4);
        check("recover_product", product, 64'd81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
